dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between two requesters: the load/store buffer's speculative loads, and the commit stage's architectural stores (including the STI second phase). It issues one non-preemptible access at a time and returns the response to whichever requester owns the port. Stores have priority, with a bounded-starvation guarantee for loads. Flushes drop in-flight load responses without ever aborting a memory transaction.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive store grants while a load waits; must be ≥1.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_req` in 1: load request from ld/str buffer; held until `ld_resp` or flush.
- `ld_addr` in 16: load address.
- `ld_resp` out 1: load complete, one cycle.
- `ld_rdata` out 16: load data, valid with `ld_resp`.
- `st_req` in 1: store request from commit; held until `st_resp`.
- `st_addr` in 16: store address.
- `st_wdata` in 16: store data.
- `st_wmask` in 2: byte enables; 2'b11 for word.
- `st_resp` out 1: store complete, one cycle.
- `flush` in 1: pipeline flush from commit on mispredict/trap.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_byte_enable` out 2: write byte enables.
- `mem_resp` in 1: memory access complete.
- `mem_rdata` in 16: memory read data.

## Operation
- FSM states: IDLE, LOAD_BUSY, STORE_BUSY, LOAD_DRAIN.
- IDLE, arbitration:
  - If both `st_req` and `ld_req` are valid: store wins unless `streak == STARVE_LIMIT`, in which case load wins.
  - A load request is valid only when `ld_req & ~flush`.
- Grant register actions: latch address, data and mask into the `mem_*` registers and assert `mem_read` or `mem_write`.
- Streak counter, width `$clog2(STARVE_LIMIT+1)`:
  - +1 on a store grant while `ld_req` is pending (saturating).
  - Cleared on a load grant, or on a store grant with no load pending.
- LOAD_BUSY:
  - On `mem_resp`: `ld_resp = ~flush`, `ld_rdata = mem_rdata`, deassert `mem_read`, go to IDLE.
  - On `flush` without `mem_resp`: go to LOAD_DRAIN.
- LOAD_DRAIN: hold `mem_read`; on `mem_resp`, suppress `ld_resp`, deassert `mem_read`, go to IDLE.
- STORE_BUSY: on `mem_resp`, `st_resp = 1`, deassert `mem_write`, go to IDLE. `flush` has no effect because stores are architectural.
- `mem_read` and `mem_write` are never asserted together.
- `mem_*` outputs are stable for the whole busy period.
- Reset, including mid-transaction:
  - State IDLE, streak 0.
  - `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `mem_byte_enable` all 0.
  - `ld_resp` and `st_resp` are 0, `ld_rdata` is 0.
  - Any outstanding access is abandoned.

## Timing
- `mem_*` outputs are registered.
- `ld_resp`, `st_resp` and `ld_rdata` are combinational from `mem_resp` and the current state.
- Request seen in IDLE at cycle N → strobe asserted at N+1.
- `mem_resp` at cycle M ≥ N+1 → requester response at M, IDLE at M+1.
- Minimum request-to-response latency is 1 cycle. Minimum occupancy per access is 2 cycles (grant cycle plus busy cycle).
- Back-to-back: a new request held at M+1 is granted at M+1, strobe at M+2.
- `flush` in the same cycle as `mem_resp` during LOAD_BUSY: response suppressed, go to IDLE directly.
- `flush` in IDLE with `ld_req` only: no grant.
- `flush` in IDLE with both requests: the store is granted.

## Configuration
- `DMEM_ARB_PERF_EN` defined: three internal 32-bit counters, initialised to 0 by reset, visible to simulation only (no ports).
  - `ld_grant_count`: +1 per load grant.
  - `st_grant_count`: +1 per store grant.
  - `ld_wait_cycles`: +1 per cycle with a valid load request not granted and not in LOAD_BUSY.
- Not defined: the counters and their logic are absent; functional behaviour is identical.

## Test plan
- Lone load:
  - Stimulus: `ld_req`, `ld_addr=0x1234`, memory responds 2 cycles after strobe with 0xBEEF.
  - Required: `mem_read` with address 0x1234 one cycle after request; `ld_resp=1` and `ld_rdata=0xBEEF` in the `mem_resp` cycle; `mem_read` low next cycle.
- Simultaneous requests:
  - Stimulus: `st_req` (addr 0x2000, wdata 0x00FF, mask 2'b01) and `ld_req` asserted together.
  - Required: store issued first with `mem_byte_enable=01`; load issued the cycle after IDLE.
- Starvation, `STARVE_LIMIT=4`:
  - Stimulus: `st_req` continuously re-asserted with `ld_req` held.
  - Required: exactly 4 store grants, then the load is granted, then stores resume.
- Flush during load:
  - Stimulus: `flush` pulsed in the second LOAD_BUSY cycle; `mem_resp` two cycles later.
  - Required: `mem_read` held until `mem_resp`; `ld_resp` stays 0; IDLE the cycle after.
- Flush during store:
  - Stimulus: `flush` pulsed in STORE_BUSY.
  - Required: `mem_write` held; `st_resp=1` on `mem_resp`.
- Reset mid-access:
  - Stimulus: `rst_n` low during LOAD_BUSY.
  - Required: all `mem_*` outputs 0 immediately (asynchronous); FSM IDLE; streak 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (load buffer, commit stores)
// and the single data-memory port. "slave" is the arbiter's view, "master" the environment's.
interface dmem_arbiter_if;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_resp;
  logic [15:0] ld_rdata;

  logic        st_req;
  logic [15:0] st_addr;
  logic [15:0] st_wdata;
  logic [1:0]  st_wmask;
  logic        st_resp;

  logic        flush;

  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport slave (
    input  ld_req, ld_addr, st_req, st_addr, st_wdata, st_wmask, flush,
           mem_resp, mem_rdata,
    output ld_resp, ld_rdata, st_resp,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output ld_req, ld_addr, st_req, st_addr, st_wdata, st_wmask, flush,
           mem_resp, mem_rdata,
    input  ld_resp, ld_rdata, st_resp,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: stores win, loads are guaranteed a grant after STARVE_LIMIT stores.
// Define DMEM_ARB_PERF_EN to add simulation-visible grant/wait performance counters.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_BUSY  = 2'd1,
    STORE_BUSY = 2'd2,
    LOAD_DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [15:0]   mem_address_q, mem_address_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_be_q, mem_be_d;

  logic          ld_valid;
  logic          grant_ld;
  logic          grant_st;
  logic          ld_resp_c;
  logic          st_resp_c;

  // A flushed load request is dead on arrival and must not win the port.
  assign ld_valid = bus.ld_req & ~bus.flush;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    grant_ld      = 1'b0;
    grant_st      = 1'b0;
    ld_resp_c     = 1'b0;
    st_resp_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.st_req && !(ld_valid && (streak_q == STREAK_MAX))) begin
          grant_st = 1'b1;
        end else if (ld_valid) begin
          grant_ld = 1'b1;
        end

        if (grant_st) begin
          state_d       = STORE_BUSY;
          mem_write_d   = 1'b1;
          mem_address_d = bus.st_addr;
          mem_wdata_d   = bus.st_wdata;
          mem_be_d      = bus.st_wmask;
          // Streak only measures how long a live load has been passed over.
          if (ld_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_ONE;
          end else begin
            streak_d = '0;
          end
        end else if (grant_ld) begin
          state_d       = LOAD_BUSY;
          mem_read_d    = 1'b1;
          mem_address_d = bus.ld_addr;
          mem_be_d      = 2'b00;
          streak_d      = '0;
        end
      end

      LOAD_BUSY: begin
        if (bus.mem_resp) begin
          ld_resp_c  = ~bus.flush;
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end else if (bus.flush) begin
          state_d = LOAD_DRAIN;
        end
      end

      // The memory access cannot be aborted; wait it out and discard the data.
      LOAD_DRAIN: begin
        if (bus.mem_resp) begin
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end
      end

      STORE_BUSY: begin
        if (bus.mem_resp) begin
          st_resp_c   = 1'b1;
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.ld_resp         = ld_resp_c;
  assign bus.st_resp         = st_resp_c;
  assign bus.ld_rdata        = ld_resp_c ? bus.mem_rdata : 16'h0000;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] ld_grant_count;
  logic [31:0] st_grant_count;
  logic [31:0] ld_wait_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_grant_count <= '0;
      st_grant_count <= '0;
      ld_wait_cycles <= '0;
    end else begin
      if (grant_ld) begin
        ld_grant_count <= ld_grant_count + 32'd1;
      end
      if (grant_st) begin
        st_grant_count <= st_grant_count + 32'd1;
      end
      if (ld_valid && !grant_ld && (state_q != LOAD_BUSY)) begin
        ld_wait_cycles <= ld_wait_cycles + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read_q && mem_write_q));

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q != IDLE) && !bus.mem_resp) |=> $stable(mem_address_q));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level model of the port owner.
module tb_dmem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Values driven onto the bus in the next cycle.
  logic        d_ld_req, d_st_req, d_flush, d_mem_resp;
  logic [15:0] d_ld_addr, d_st_addr, d_st_wdata, d_mem_rdata;
  logic [1:0]  d_st_wmask;

  // Model: who owns the memory port (0 none, 1 load, 2 store) and what was latched.
  int          m_owner;
  bit          m_drop;
  int          m_streak;
  logic [15:0] m_addr, m_wdata;
  logic [1:0]  m_mask;
  bit          ev_ld_resp, ev_st_resp;
  int          grant_log[$];
  logic [15:0] tb_mem [logic [15:0]];

  // Random requester state.
  bit          lq_on, sq_on;
  logic [15:0] lq_addr, sq_addr, sq_data;
  logic [1:0]  sq_mask;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return a ^ 16'h5A3C;
  endfunction

  task automatic set_idle();
    d_ld_req = 1'b0; d_ld_addr = 16'h0; d_st_req = 1'b0; d_st_addr = 16'h0;
    d_st_wdata = 16'h0; d_st_wmask = 2'b00; d_flush = 1'b0;
    d_mem_resp = 1'b0; d_mem_rdata = 16'h0;
  endtask

  task automatic drive();
    bus.ld_req = d_ld_req;     bus.ld_addr = d_ld_addr;
    bus.st_req = d_st_req;     bus.st_addr = d_st_addr;
    bus.st_wdata = d_st_wdata; bus.st_wmask = d_st_wmask;
    bus.flush = d_flush;       bus.mem_resp = d_mem_resp;
    bus.mem_rdata = d_mem_rdata;
  endtask

  task automatic model_reset();
    m_owner = 0; m_drop = 0; m_streak = 0;
    m_addr = 16'h0; m_wdata = 16'h0; m_mask = 2'b00;
    grant_log.delete();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_mem_read"},  32'(bus.mem_read), 32'd0);
    check_eq({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    check_eq({tag, "_mem_addr"},  32'(bus.mem_address), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_eq({tag, "_mem_be"},    32'(bus.mem_byte_enable), 32'd0);
    check_eq({tag, "_ld_resp"},   32'(bus.ld_resp), 32'd0);
    check_eq({tag, "_st_resp"},   32'(bus.st_resp), 32'd0);
    check_eq({tag, "_ld_rdata"},  32'(bus.ld_rdata), 32'd0);
  endtask

  // Called at a falling edge: reset lands mid-cycle, outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    set_idle();
    drive();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle();
    bit exp_ld, exp_st, ldv, take_st;
    logic [15:0] old;
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    check_eq("mem_read", 32'(bus.mem_read), 32'(m_owner == 1));
    check_eq("mem_write", 32'(bus.mem_write), 32'(m_owner == 2));
    if (m_owner != 0) check_eq("mem_address", 32'(bus.mem_address), 32'(m_addr));
    if (m_owner == 2) begin
      check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      check_eq("mem_byte_enable", 32'(bus.mem_byte_enable), 32'(m_mask));
    end
    exp_ld = (m_owner == 1) && d_mem_resp && !d_flush && !m_drop;
    exp_st = (m_owner == 2) && d_mem_resp;
    check_eq("ld_resp", 32'(bus.ld_resp), 32'(exp_ld));
    check_eq("st_resp", 32'(bus.st_resp), 32'(exp_st));
    check_eq("ld_rdata", 32'(bus.ld_rdata), exp_ld ? 32'(d_mem_rdata) : 32'd0);
    ev_ld_resp = exp_ld;
    ev_st_resp = exp_st;

    if (m_owner == 0) begin
      ldv = d_ld_req && !d_flush;
      take_st = d_st_req && !(ldv && m_streak == STARVE_LIMIT);
      if (take_st) begin
        m_owner = 2; m_addr = d_st_addr; m_wdata = d_st_wdata; m_mask = d_st_wmask;
        m_streak = ldv ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : m_streak) : 0;
        grant_log.push_back(2);
      end else if (ldv) begin
        m_owner = 1; m_addr = d_ld_addr; m_drop = 0; m_streak = 0;
        grant_log.push_back(1);
      end
    end else if (d_mem_resp) begin
      if (m_owner == 2) begin
        old = mem_word(m_addr);
        tb_mem[m_addr] = {m_mask[1] ? m_wdata[15:8] : old[15:8],
                          m_mask[0] ? m_wdata[7:0]  : old[7:0]};
      end
      m_owner = 0; m_drop = 0;
    end else if (m_owner == 1 && d_flush) begin
      m_drop = 1;
    end
  endtask

  task automatic rand_cycle(input int p_ld, input int p_st, input int p_flush, input int p_resp);
    if (!lq_on && int'($urandom_range(99)) < p_ld) begin
      lq_on = 1; lq_addr = 16'h0100 + 16'($urandom_range(15));
    end
    if (!sq_on && int'($urandom_range(99)) < p_st) begin
      sq_on = 1; sq_addr = 16'h0100 + 16'($urandom_range(15));
      sq_data = 16'($urandom); sq_mask = 2'($urandom_range(1, 3));
    end
    d_ld_req = lq_on;  d_ld_addr = lq_on ? lq_addr : 16'($urandom);
    d_st_req = sq_on;  d_st_addr = sq_on ? sq_addr : 16'($urandom);
    d_st_wdata = sq_on ? sq_data : 16'($urandom);
    d_st_wmask = sq_on ? sq_mask : 2'($urandom);
    d_flush = int'($urandom_range(99)) < p_flush;
    d_mem_resp = (m_owner != 0) && (int'($urandom_range(99)) < p_resp);
    d_mem_rdata = (d_mem_resp && m_owner == 1) ? mem_word(m_addr) : 16'($urandom);
    cycle();
    if (ev_ld_resp || d_flush) lq_on = 0;
    if (ev_st_resp) sq_on = 0;
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{2, 2, 2, 2, 1, 2};

    // Power-on reset.
    set_idle(); drive(); model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk) rst_n = 1'b1;

    // Lone load: strobe one cycle after the request, response two cycles after strobe.
    set_idle(); d_ld_req = 1; d_ld_addr = 16'h1234;
    cycle();
    cycle();
    check_eq("lone_mem_read", 32'(bus.mem_read), 32'd1);
    check_eq("lone_addr", 32'(bus.mem_address), 32'h1234);
    cycle();
    d_mem_resp = 1; d_mem_rdata = 16'hBEEF;
    cycle();
    check_eq("lone_ld_resp", 32'(bus.ld_resp), 32'd1);
    check_eq("lone_ld_rdata", 32'(bus.ld_rdata), 32'hBEEF);
    set_idle();
    cycle();
    check_eq("lone_read_low", 32'(bus.mem_read), 32'd0);

    // Simultaneous store and load: store first, load in the following IDLE cycle.
    set_idle();
    d_st_req = 1; d_st_addr = 16'h2000; d_st_wdata = 16'h00FF; d_st_wmask = 2'b01;
    d_ld_req = 1; d_ld_addr = 16'h3000;
    cycle();
    d_mem_resp = 1;
    cycle();
    check_eq("sim_st_write", 32'(bus.mem_write), 32'd1);
    check_eq("sim_st_be", 32'(bus.mem_byte_enable), 32'b01);
    check_eq("sim_st_resp", 32'(bus.st_resp), 32'd1);
    d_st_req = 0; d_mem_resp = 0;
    cycle();
    cycle();
    check_eq("sim_ld_read", 32'(bus.mem_read), 32'd1);
    check_eq("sim_ld_addr", 32'(bus.mem_address), 32'h3000);
    d_mem_resp = 1; d_mem_rdata = 16'h4321;
    cycle();
    set_idle();
    cycle();

    // Flush in the second busy cycle of a load; memory answers two cycles later.
    set_idle(); d_ld_req = 1; d_ld_addr = 16'h0ABC;
    cycle();
    cycle();
    d_flush = 1;
    cycle();
    d_flush = 0; d_ld_req = 0;
    cycle();
    check_eq("fl_read_held", 32'(bus.mem_read), 32'd1);
    d_mem_resp = 1; d_mem_rdata = 16'h7777;
    cycle();
    check_eq("fl_read_resp", 32'(bus.mem_read), 32'd1);
    check_eq("fl_ld_resp", 32'(bus.ld_resp), 32'd0);
    d_mem_resp = 0; d_ld_req = 1; d_ld_addr = 16'h0DEF;
    cycle();
    check_eq("fl_idle_read", 32'(bus.mem_read), 32'd0);
    cycle();
    check_eq("fl_regrant_addr", 32'(bus.mem_address), 32'h0DEF);
    d_mem_resp = 1; d_mem_rdata = 16'h1111;
    cycle();
    set_idle();
    cycle();

    // Flush during a store has no effect.
    set_idle(); d_st_req = 1; d_st_addr = 16'h0440; d_st_wdata = 16'hA5A5; d_st_wmask = 2'b11;
    cycle();
    cycle();
    d_flush = 1;
    cycle();
    check_eq("fs_write_held", 32'(bus.mem_write), 32'd1);
    d_flush = 0; d_mem_resp = 1;
    cycle();
    check_eq("fs_st_resp", 32'(bus.st_resp), 32'd1);
    set_idle();
    cycle();
    check_eq("fs_write_low", 32'(bus.mem_write), 32'd0);

    // Reset while a load is outstanding, with mem_resp already high.
    set_idle(); d_ld_req = 1; d_ld_addr = 16'h5555;
    cycle();
    cycle();
    d_mem_resp = 1; d_mem_rdata = 16'h9999; drive();
    async_reset("rst_ld");

    // Build a store streak of 2 against a waiting load, then reset during the store.
    set_idle();
    d_ld_req = 1; d_ld_addr = 16'h0600;
    d_st_req = 1; d_st_addr = 16'h0700; d_st_wdata = 16'h1357; d_st_wmask = 2'b11;
    cycle();
    d_mem_resp = 1;
    cycle();
    d_mem_resp = 0;
    cycle();
    cycle();
    check_eq("pre_rst_write", 32'(bus.mem_write), 32'd1);
    async_reset("rst_st");

    // Starvation: with both requests always present, exactly 4 stores then the load.
    d_ld_req = 1; d_ld_addr = 16'h0800;
    d_st_req = 1; d_st_addr = 16'h0900; d_st_wdata = 16'hCAFE; d_st_wmask = 2'b10;
    for (int i = 0; i < 100 && grant_log.size() < 6; i++) begin
      d_mem_resp = (m_owner != 0);
      d_mem_rdata = 16'h2468;
      cycle();
    end
    check_eq("starve_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check_eq($sformatf("starve_grant%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));

    // Randomized traffic from a clean start.
    @(negedge clk);
    async_reset("rst_rand");
    lq_on = 0; sq_on = 0;
    repeat (3000) rand_cycle(30, 30, 8, 40);
    repeat (500)  rand_cycle(100, 100, 0, 60);
    repeat (1500) rand_cycle(20, 15, 15, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
